// File: rtl/alu_key_sequencer_if.sv
// Key-event and datapath-status bundle shared by the key decoder (master)
// and alu_key_sequencer (slave); the display mux taps the status side.
interface alu_key_sequencer_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] result;
    logic         result_neg;
    logic         overflow;
    logic         busy;
    logic         done;
    logic [1:0]   disp_sel;

    modport master (
        output key_valid, key_code,
        input  op_a, op_b, result, result_neg, overflow, busy, done, disp_sel
    );

    modport slave (
        input  key_valid, key_code,
        output op_a, op_b, result, result_neg, overflow, busy, done, disp_sel
    );
endinterface

// File: rtl/alu_key_sequencer.sv
// Keypad-driven BCD calculator sequencer: operand entry, digit-serial add/subtract, display select.
// Optional macro ALU_CHAIN_EN: '+'/'-' in SHOW reuses the result as the next operand A.
//
//  state   | meaning
//  ENTER_A | collecting operand A digits
//  OP_WAIT | operator latched, waiting for first B digit
//  ENTER_B | collecting operand B digits, '=' starts the calculation
//  CALC    | one BCD digit per cycle, LSD first (second pass for negative results)
//  SHOW    | result displayed, done pulsed on entry
module alu_key_sequencer #(
    parameter int DIGITS = 4
) (
    input logic                clk,
    input logic                reset,
    alu_key_sequencer_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        ENTER_A,
        OP_WAIT,
        ENTER_B,
        CALC,
        SHOW
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  op_a_q, op_a_d;
    logic [W-1:0]  op_b_q, op_b_d;
    logic [W-1:0]  result_q, result_d;
    logic          neg_q, neg_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    disp_sel_q, disp_sel_d;
    logic          sub_q, sub_d;
    logic          a_ent_q, a_ent_d;
    logic          pass2_q, pass2_d;
    logic          cy_q, cy_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          key_digit, key_op, key_eq, key_clr, key_sub;
    logic          a_full, b_full, last_digit;
    logic [W-1:0]  a_sh, b_sh;
    logic [3:0]    dig_a, dig_b, res_dig;
    logic [4:0]    add_s, sub_s;
    logic          cout;

    assign key_digit  = bus.key_valid && (bus.key_code <= 4'd9);
    assign key_op     = bus.key_valid && (bus.key_code == 4'b1010 || bus.key_code == 4'b1011);
    assign key_eq     = bus.key_valid && (bus.key_code == 4'b1100);
    assign key_clr    = bus.key_valid && (bus.key_code == 4'b1111);
    assign key_sub    = bus.key_code[0];
    assign a_full     = (op_a_q[W-1 -: 4] != 4'd0);
    assign b_full     = (op_b_q[W-1 -: 4] != 4'd0);
    assign last_digit = (idx_q == IW'(DIGITS - 1));

    // Pass 2 reuses the subtractor as 0 - pass1, i.e. the ten's complement.
    always_comb begin
        a_sh    = op_a_q >> (4 * idx_q);
        b_sh    = op_b_q >> (4 * idx_q);
        dig_a   = pass2_q ? 4'd0 : a_sh[3:0];
        dig_b   = pass2_q ? result_q[3:0] : b_sh[3:0];
        add_s   = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, cy_q};
        sub_s   = {1'b0, dig_a} - {1'b0, dig_b} - {4'd0, cy_q};
        res_dig = 4'd0;
        cout    = 1'b0;
        if (sub_q) begin
            cout    = sub_s[4];
            res_dig = cout ? (sub_s[3:0] + 4'd10) : sub_s[3:0];
        end else begin
            cout    = (add_s > 5'd9);
            res_dig = cout ? (add_s[3:0] + 4'd6) : add_s[3:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        result_d   = result_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        disp_sel_d = disp_sel_q;
        sub_d      = sub_q;
        a_ent_d    = a_ent_q;
        pass2_d    = pass2_q;
        cy_d       = cy_q;
        idx_d      = idx_q;

        case (state_q)
            ENTER_A: begin
                if (key_digit) begin
                    if (!a_full) op_a_d = {op_a_q[W-5:0], bus.key_code};
                    a_ent_d    = 1'b1;
                    disp_sel_d = 2'd1;
                end else if (key_op && a_ent_q) begin
                    sub_d   = key_sub;
                    state_d = OP_WAIT;
                end
            end
            OP_WAIT: begin
                if (key_digit) begin
                    op_b_d     = {{(W-4){1'b0}}, bus.key_code};
                    disp_sel_d = 2'd2;
                    state_d    = ENTER_B;
                end else if (key_op) begin
                    sub_d = key_sub;
                end
            end
            ENTER_B: begin
                if (key_digit) begin
                    if (!b_full) op_b_d = {op_b_q[W-5:0], bus.key_code};
                end else if (key_eq) begin
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    cy_d    = 1'b0;
                    pass2_d = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                result_d = {res_dig, result_q[W-1:4]};
                cy_d     = cout;
                idx_d    = idx_q + IW'(1);
                if (last_digit) begin
                    idx_d = '0;
                    if (sub_q && !pass2_q && cout) begin
                        pass2_d = 1'b1;
                        cy_d    = 1'b0;
                    end else begin
                        if (!sub_q) ovf_d = cout;
                        neg_d      = pass2_q;
                        pass2_d    = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        disp_sel_d = 2'd3;
                        state_d    = SHOW;
                    end
                end
            end
            SHOW: begin
                if (key_digit) begin
                    op_a_d     = {{(W-4){1'b0}}, bus.key_code};
                    op_b_d     = '0;
                    result_d   = '0;
                    neg_d      = 1'b0;
                    ovf_d      = 1'b0;
                    sub_d      = 1'b0;
                    a_ent_d    = 1'b1;
                    disp_sel_d = 2'd1;
                    state_d    = ENTER_A;
                end else if (key_op) begin
`ifdef ALU_CHAIN_EN
                    if (!neg_q && !ovf_q) begin
                        op_a_d     = result_q;
                        op_b_d     = '0;
                        sub_d      = key_sub;
                        a_ent_d    = 1'b1;
                        disp_sel_d = 2'd1;
                        state_d    = OP_WAIT;
                    end
`endif
                end
            end
            default: state_d = ENTER_A;
        endcase

        // Clear wins over everything, including an in-flight calculation.
        if (key_clr) begin
            state_d    = ENTER_A;
            op_a_d     = '0;
            op_b_d     = '0;
            result_d   = '0;
            neg_d      = 1'b0;
            ovf_d      = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            disp_sel_d = 2'd0;
            sub_d      = 1'b0;
            a_ent_d    = 1'b0;
            pass2_d    = 1'b0;
            cy_d       = 1'b0;
            idx_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ENTER_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            result_q   <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            disp_sel_q <= 2'd0;
            sub_q      <= 1'b0;
            a_ent_q    <= 1'b0;
            pass2_q    <= 1'b0;
            cy_q       <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            result_q   <= result_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            disp_sel_q <= disp_sel_d;
            sub_q      <= sub_d;
            a_ent_q    <= a_ent_d;
            pass2_q    <= pass2_d;
            cy_q       <= cy_d;
            idx_q      <= idx_d;
        end
    end

    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.result     = result_q;
    assign bus.result_neg = neg_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.disp_sel   = disp_sel_q;
endmodule

// File: tb/tb_alu_key_sequencer.sv
// Randomized + directed bench for alu_key_sequencer against a decimal-integer calculator model.
module tb_alu_key_sequencer;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int P      = 10 ** DIGITS;

    logic clk = 1'b0;
    logic reset = 1'b0;

    alu_key_sequencer_if #(.DIGITS(DIGITS)) bus ();
    alu_key_sequencer #(.DIGITS(DIGITS)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 entering A, 1 operator pending, 2 entering B, 3 showing result
    int m_state, m_a, m_b, m_res, m_lat;
    bit m_ent, m_sub, m_neg, m_ovf;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | (W'(t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_lat = 0;
        m_ent = 0; m_sub = 0; m_neg = 0; m_ovf = 0;
    endfunction

    function automatic void m_calc();
        int s;
        if (!m_sub) begin
            s     = m_a + m_b;
            m_ovf = (s >= P);
            m_res = s % P;
            m_lat = DIGITS;
        end else begin
            s     = m_a - m_b;
            m_neg = (s < 0);
            m_res = (s < 0) ? -s : s;
            m_lat = m_neg ? 2 * DIGITS : DIGITS;
        end
    endfunction

    function automatic bit m_apply(input logic [3:0] k);
        bit go;
        int d;
        go = 0;
        d  = int'(k);
        if (k == 4'd15) begin
            m_reset();
            return 0;
        end
        case (m_state)
            0: if (k <= 4'd9) begin
                   if (m_a < P / 10) m_a = m_a * 10 + d;
                   m_ent = 1;
               end else if ((k == 4'd10 || k == 4'd11) && m_ent) begin
                   m_sub = (k == 4'd11); m_state = 1;
               end
            1: if (k <= 4'd9) begin
                   m_b = d; m_state = 2;
               end else if (k == 4'd10 || k == 4'd11) begin
                   m_sub = (k == 4'd11);
               end
            2: if (k <= 4'd9) begin
                   if (m_b < P / 10) m_b = m_b * 10 + d;
               end else if (k == 4'd12) begin
                   m_calc(); m_state = 3; go = 1;
               end
            default: if (k <= 4'd9) begin
                   m_reset(); m_a = d; m_ent = 1;
               end else if (k == 4'd10 || k == 4'd11) begin
`ifdef ALU_CHAIN_EN
                   if (!m_neg && !m_ovf) begin
                       m_a = m_res; m_b = 0; m_sub = (k == 4'd11);
                       m_ent = 1; m_state = 1;
                   end
`endif
               end
        endcase
        return go;
    endfunction

    function automatic int m_disp();
        case (m_state)
            0:       return m_ent ? 1 : 0;
            1:       return 1;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check_all(input string tag, input bit exp_done);
        check_val({tag, ".op_a"},   32'(bus.op_a),       32'(to_bcd(m_a)));
        check_val({tag, ".op_b"},   32'(bus.op_b),       32'(to_bcd(m_b)));
        check_val({tag, ".result"}, 32'(bus.result),     32'(to_bcd(m_res)));
        check_val({tag, ".neg"},    32'(bus.result_neg), 32'(m_neg));
        check_val({tag, ".ovf"},    32'(bus.overflow),   32'(m_ovf));
        check_val({tag, ".busy"},   32'(bus.busy),       32'(0));
        check_val({tag, ".done"},   32'(bus.done),       32'(exp_done));
        check_val({tag, ".disp"},   32'(bus.disp_sel),   32'(m_disp()));
    endtask

    task automatic press(input logic [3:0] k);
        bit start, stable;
        int cnt;
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        start = m_apply(k);
        if (start) begin
            check_val("calc_busy", 32'(bus.busy), 32'(1));
            check_val("calc_disp", 32'(bus.disp_sel), 32'(2));
            cnt    = 0;
            stable = 1;
            while (bus.busy && cnt < 3 * DIGITS) begin
                @(posedge clk); #1;
                cnt++;
                if (bus.op_a !== to_bcd(m_a) || bus.op_b !== to_bcd(m_b)) stable = 0;
            end
            check_val("calc_latency", 32'(cnt), 32'(m_lat));
            check_val("calc_operands_stable", 32'(stable), 32'(1));
            check_all("show", 1'b1);
            @(posedge clk); #1;
            check_val("done_pulse_width", 32'(bus.done), 32'(0));
        end else begin
            check_all("key", 1'b0);
        end
    endtask

    task automatic press_seq(input logic [3:0] ks[$]);
        foreach (ks[i]) press(ks[i]);
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all("after_reset", 1'b0);

        // 12 + 34 = 46
        press_seq('{4'd1, 4'd2, 4'd10, 4'd3, 4'd4, 4'd12});
        check_val("t1_result", 32'(bus.result), 32'h0046);

        // 15 - 40 = -25
        press_seq('{4'd1, 4'd5, 4'd11, 4'd4, 4'd0, 4'd12});
        check_val("t2_result", 32'(bus.result), 32'h0025);
        check_val("t2_neg", 32'(bus.result_neg), 32'(1));

        // 9999 (+ ignored 5th digit) + 1 overflows
        press_seq('{4'd9, 4'd9, 4'd9, 4'd9, 4'd9});
        check_val("t3_full_a", 32'(bus.op_a), 32'h9999);
        press_seq('{4'd10, 4'd1, 4'd12});
        check_val("t3_ovf", 32'(bus.overflow), 32'(1));

        // Clear on the second CALC cycle
        press_seq('{4'd1, 4'd2, 4'd10, 4'd3});
        bus.key_valid = 1'b1; bus.key_code = 4'd12;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        void'(m_apply(4'd12));
        check_val("t4_busy", 32'(bus.busy), 32'(1));
        @(posedge clk); #1;
        bus.key_valid = 1'b1; bus.key_code = 4'd15;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        m_reset();
        check_all("t4_clear_in_calc", 1'b0);

        // Operators before digits ignored; last operator in OP_WAIT wins
        press_seq('{4'd10, 4'd12, 4'd7, 4'd10, 4'd11, 4'd2, 4'd12});
        check_val("t5_result", 32'(bus.result), 32'h0005);

        // Chaining from SHOW
        press_seq('{4'd2, 4'd10, 4'd3, 4'd12, 4'd10});
`ifdef ALU_CHAIN_EN
        check_val("t6_chain_a", 32'(bus.op_a), 32'h0005);
        press_seq('{4'd4, 4'd12});
        check_val("t6_result", 32'(bus.result), 32'h0009);
`else
        check_val("t6_no_chain", 32'(bus.result), 32'h0005);
        press_seq('{4'd4, 4'd12});
`endif

        press(4'd15);
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [3:0] k;
            r = int'($urandom_range(0, 99));
            if (r < 55)      k = 4'($urandom_range(0, 9));
            else if (r < 70) k = 4'($urandom_range(10, 11));
            else if (r < 84) k = 4'd12;
            else if (r < 88) k = 4'd15;
            else if (r < 92) k = 4'($urandom_range(13, 14));
            else             k = 4'($urandom_range(0, 9));
            press(k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
